stage_seq: RTL and testbench
============================

Name: stage_seq

Overview:
- Parametrised multi-cycle stage sequencer for the rv32 core family.
- Replaces the fixed 4-state fetch/decode/execute/writeback controller with an N-stage one-hot sequencer.
- Adds a pipeline-wide stall, exception redirect to a configurable stage, a per-stage watchdog timeout, and an instruction-retire count.
- Sits at core top level: drives per-stage enables, consumes per-stage ready strobes.

Parameters:
- NUM_STG, 4, number of stages (2..8); stage 0 is the first stage, NUM_STG-1 is the last.
- EXC_STG, 1, stage entered on exception or timeout (0..NUM_STG-1).
- TMO_W, 8, watchdog counter width; timeout fires after 2^TMO_W-1 cycles without ready.
- CNT_W, 32, width of the retire counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- stall_i  in  1  freeze the sequencer (held stage, no advance, watchdog frozen)
- exc_i  in  1  exception request from the CSR unit
- stg_ready_i  in  NUM_STG  per-stage done strobe; only the bit of the current stage is used
- stg_en_o  out  NUM_STG  one-hot enable of the current stage
- stg_idx_o  out  $clog2(NUM_STG)  binary index of the current stage
- stg_first_o  out  1  high on the first cycle spent in the current stage
- retire_o  out  1  single-cycle pulse when the last stage completes
- tmo_o  out  1  sticky watchdog-timeout flag
- instret_o  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_i high at a clock edge):
  - stg_idx_o=0, stg_en_o=1 (bit 0), stg_first_o=1.
  - retire_o=0, tmo_o=0, instret_o=0, watchdog=0.
  - Reset wins over every other event, including mid-stall and mid-exception.
- Next-state priority each cycle, highest first: rst_i > exc_i > timeout > stall_i > ready advance.
- exc_i=1: next stage is EXC_STG, regardless of current stage or stall_i. This is a single-cycle redirect; stg_first_o=1 on the next cycle, even if already in EXC_STG.
- Timeout: when the watchdog equals 2^TMO_W-1 and the current-stage ready is low:
  - next stage is EXC_STG;
  - tmo_o is set and held until reset.
- stall_i=1 (no exc_i, no timeout): stage, watchdog and stg_first_o are held. stg_ready_i is ignored.
- Advance: when stg_ready_i[stg_idx_o]=1, next stage is stg_idx+1. Advancing from NUM_STG-1 wraps to 0.
- stg_first_o is registered: 1 on the cycle after any stage change (advance, wrap, redirect, reset), otherwise 0.
- Watchdog:
  - cleared on any stage change;
  - incremented each non-stalled cycle in which the current ready is low;
  - saturates at the timeout value, never wraps.
- retire_o is combinational: stg_en_o[NUM_STG-1] & stg_ready_i[NUM_STG-1] & ~stall_i & ~exc_i & ~rst_i.
- instret_o increments by 1 on the edge where retire_o=1 and wraps modulo 2^CNT_W.
- If exc_i and last-stage ready arrive in the same cycle, the exception wins: no retire, no increment.
- Non-current stg_ready_i bits have no effect.
- stg_en_o is always exactly one-hot. stg_idx_o always matches stg_en_o.
- Latency: one cycle from ready (or exc_i) to the new stage enable.

Optional Feature:
- Macro: STAGE_SEQ_PERF_EN.
- Defined: adds outputs cyc_cnt_o [CNT_W] and stall_cnt_o [CNT_W].
  - cyc_cnt_o counts every non-reset cycle.
  - stall_cnt_o counts cycles with stall_i=1.
  - Both reset to 0 and wrap.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Decomposition:
- Shared package stage_seq_pkg holds:
  - the default stage-index constants STG_FETCH=0, STG_DEC=1, STG_EXE=2, STG_WRBK=3;
  - the default EXC_STG value;
  - a function returning the width for a stage count.
- One sub-module, seq_wdog: watchdog counter with clear, enable and saturate-flag outputs.
- Stage register, retire logic and counters stay in stage_seq.

Test Plan:
- Reset then all ready bits high continuously, NUM_STG=4 -> stg_idx sequence 0,1,2,3,0,1; retire_o pulses every 4th cycle; instret_o=2 after 8 cycles.
- In stage 2, stall_i=1 for 5 cycles with ready high -> stg_idx stays 2, no retire, watchdog unchanged; advances to 3 one cycle after stall drops.
- In stage 3 with ready high, assert exc_i -> next stg_idx=1 (EXC_STG), stg_first_o=1, retire_o=0, instret_o unchanged.
- TMO_W=4, hold stage 2 with ready low -> after 15 cycles stg_idx=1, tmo_o=1, and tmo_o stays 1 until rst_i.
- Assert rst_i during stall plus exc_i -> next cycle stg_idx=0, instret_o=0, tmo_o=0, stg_first_o=1.
- STAGE_SEQ_PERF_EN defined, 10 cycles with 3 stalled -> cyc_cnt_o=10, stall_cnt_o=3.

Source files
------------

// File: rtl/stage_seq_pkg.sv
// Shared definitions for the stage sequencer: default stage numbering,
// the per-cycle sequencing action, and the stage-index width helper.
package stage_seq_pkg;

  localparam int STG_FETCH = 0;
  localparam int STG_DEC   = 1;
  localparam int STG_EXE   = 2;
  localparam int STG_WRBK  = 3;

  localparam int NUM_STG_DEF = 4;
  localparam int EXC_STG_DEF = STG_DEC;

  // What the sequencer does at the next edge, listed in priority order.
  typedef enum logic [2:0] {
    ACT_RST,
    ACT_EXC,
    ACT_TMO,
    ACT_STALL,
    ACT_ADV,
    ACT_WAIT
  } seq_act_e;

  function automatic int stg_idx_w(input int num_stg);
    return (num_stg > 1) ? $clog2(num_stg) : 1;
  endfunction

endpackage

// File: rtl/stage_seq_if.sv
// Core-facing bundle of the stage sequencer: stage enables out, stage
// ready strobes / stall / exception in, plus retire and status outputs.
interface stage_seq_if
  import stage_seq_pkg::*;
#(
  parameter int NUM_STG = NUM_STG_DEF,
  parameter int CNT_W   = 32
);

  localparam int IDX_W = stg_idx_w(NUM_STG);

  logic                 stall_i;
  logic                 exc_i;
  logic [NUM_STG-1:0]   stg_ready_i;
  logic [NUM_STG-1:0]   stg_en_o;
  logic [IDX_W-1:0]     stg_idx_o;
  logic                 stg_first_o;
  logic                 retire_o;
  logic                 tmo_o;
  logic [CNT_W-1:0]     instret_o;

  // The sequencer side.
  modport master (
    input  stall_i, exc_i, stg_ready_i,
    output stg_en_o, stg_idx_o, stg_first_o, retire_o, tmo_o, instret_o
  );

  // The core side, which consumes enables and returns ready strobes.
  modport slave (
    output stall_i, exc_i, stg_ready_i,
    input  stg_en_o, stg_idx_o, stg_first_o, retire_o, tmo_o, instret_o
  );

endinterface

// File: rtl/stage_seq_wdog.sv
// Per-stage watchdog: counts stuck cycles, clears on stage change and
// saturates at all-ones, flagging the timeout condition.
module seq_wdog #(
  parameter int TMO_W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic sat_o
);

  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  logic [TMO_W-1:0] cnt_q;

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sat_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/stage_seq.sv
// N-stage one-hot stage sequencer with stall, exception/timeout redirect
// and retire counting. Define STAGE_SEQ_PERF_EN for cycle/stall counters.
module stage_seq
  import stage_seq_pkg::*;
#(
  parameter int NUM_STG = NUM_STG_DEF,
  parameter int EXC_STG = EXC_STG_DEF,
  parameter int TMO_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  stage_seq_if.master        seq
`ifdef STAGE_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]   cyc_cnt_o,
  output logic [CNT_W-1:0]   stall_cnt_o
`endif
);

  localparam int               IDX_W    = stg_idx_w(NUM_STG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STG - 1);
  localparam logic [IDX_W-1:0] EXC_IDX  = IDX_W'(EXC_STG);

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               first_q, first_d;
  logic               tmo_q;
  logic [CNT_W-1:0]   instret_q;
  logic [NUM_STG-1:0] en_dec;
  logic               ready_cur;
  logic               wdog_sat;
  logic               timeout;
  logic               retire;
  seq_act_e           act;

  assign ready_cur = seq.stg_ready_i[idx_q];
  assign timeout   = wdog_sat & ~ready_cur;

  // NOTE: every signal written here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    act     = ACT_WAIT;
    idx_d   = idx_q;
    first_d = 1'b0;

    if (rst_i)               act = ACT_RST;
    else if (seq.exc_i)      act = ACT_EXC;
    else if (timeout)        act = ACT_TMO;
    else if (seq.stall_i)    act = ACT_STALL;
    else if (ready_cur)      act = ACT_ADV;

    case (act)
      ACT_RST: begin
        idx_d   = '0;
        first_d = 1'b1;
      end
      ACT_EXC, ACT_TMO: begin
        idx_d   = EXC_IDX;
        first_d = 1'b1;
      end
      ACT_STALL: first_d = first_q;
      ACT_ADV: begin
        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        first_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      first_q   <= 1'b1;
      tmo_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      idx_q   <= idx_d;
      first_q <= first_d;
      if (act == ACT_TMO) tmo_q <= 1'b1;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  // A redirect counts as a stage change even when it lands on the same stage.
  seq_wdog #(.TMO_W(TMO_W)) u_wdog (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (act inside {ACT_EXC, ACT_TMO, ACT_ADV}),
    .en_i  (act == ACT_WAIT),
    .sat_o (wdog_sat)
  );

  always_comb begin
    en_dec        = '0;
    en_dec[idx_q] = 1'b1;
  end

  assign retire = en_dec[NUM_STG-1] & seq.stg_ready_i[NUM_STG-1]
                & ~seq.stall_i & ~seq.exc_i & ~rst_i;

  assign seq.stg_en_o    = en_dec;
  assign seq.stg_idx_o   = idx_q;
  assign seq.stg_first_o = first_q;
  assign seq.retire_o    = retire;
  assign seq.tmo_o       = tmo_q;
  assign seq.instret_o   = instret_q;

`ifdef STAGE_SEQ_PERF_EN
  logic [CNT_W-1:0] cyc_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_q + 1'b1;
      if (seq.stall_i) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign cyc_cnt_o   = cyc_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stage_seq.sv
// Scoreboard bench for stage_seq: a cycle-level reference model queues the
// expected outputs of each cycle, and a monitor compares them on the falling edge.
module tb_stage_seq;

  localparam int NUM_STG = 4;
  localparam int EXC_STG = 1;
  localparam int TMO_W   = 4;
  localparam int CNT_W   = 6;
  localparam int WD_MAX  = (1 << TMO_W) - 1;
  localparam int CNT_MOD = 1 << CNT_W;

  typedef struct {
    int          idx;
    bit          first;
    bit          retire;
    bit          tmo;
    int unsigned instret;
    int unsigned cyc;
    int unsigned stl;
  } exp_t;

  logic clk_i;
  logic rst_i;

  stage_seq_if #(.NUM_STG(NUM_STG), .CNT_W(CNT_W)) sif ();

`ifdef STAGE_SEQ_PERF_EN
  logic [CNT_W-1:0] cyc_cnt, stall_cnt;
`endif

  stage_seq #(
    .NUM_STG (NUM_STG),
    .EXC_STG (EXC_STG),
    .TMO_W   (TMO_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .seq   (sif)
`ifdef STAGE_SEQ_PERF_EN
    ,
    .cyc_cnt_o   (cyc_cnt),
    .stall_cnt_o (stall_cnt)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state, in plain integers.
  int          m_stg;
  int          m_wd;
  bit          m_first;
  bit          m_tmo;
  int unsigned m_instret;
  int unsigned m_cyc;
  int unsigned m_stl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_stg = 0; m_wd = 0; m_first = 1'b1; m_tmo = 1'b0;
    m_instret = 0; m_cyc = 0; m_stl = 0;
  endtask

  // Drive one cycle of inputs, queue what the outputs must show during it,
  // then advance the model to the next cycle.
  task automatic step(input bit rst, input bit stall, input bit exc,
                      input logic [NUM_STG-1:0] rdy);
    exp_t e;
    bit   cur;
    rst_i           = rst;
    sif.stall_i     = stall;
    sif.exc_i       = exc;
    sif.stg_ready_i = rdy;

    cur = rdy[m_stg];
    e.idx     = m_stg;
    e.first   = m_first;
    e.tmo     = m_tmo;
    e.instret = m_instret;
    e.cyc     = m_cyc;
    e.stl     = m_stl;
    e.retire  = (m_stg == NUM_STG - 1) && cur && !stall && !exc && !rst;
    exp_q.push_back(e);

    if (rst) begin
      model_reset();
    end else begin
      m_cyc = (m_cyc + 1) % CNT_MOD;
      if (stall) m_stl = (m_stl + 1) % CNT_MOD;
      if (e.retire) m_instret = (m_instret + 1) % CNT_MOD;
      if (exc) begin
        m_stg = EXC_STG; m_wd = 0; m_first = 1'b1;
      end else if (m_wd == WD_MAX && !cur) begin
        m_stg = EXC_STG; m_wd = 0; m_first = 1'b1; m_tmo = 1'b1;
      end else if (stall) begin
        // everything held
      end else if (cur) begin
        m_stg = (m_stg + 1) % NUM_STG; m_wd = 0; m_first = 1'b1;
      end else begin
        m_wd    = (m_wd < WD_MAX) ? m_wd + 1 : WD_MAX;
        m_first = 1'b0;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic goto_stage(input int s);
    for (int i = 0; i < NUM_STG && m_stg != s; i++) step(0, 0, 0, '1);
  endtask

  // Random cycle: current-stage ready with probability p_rdy percent,
  // the other ready bits random.
  task automatic rand_step(input int p_rst, input int p_exc, input int p_stall, input int p_rdy);
    logic [NUM_STG-1:0] rdy;
    rdy        = NUM_STG'($urandom());
    rdy[m_stg] = ($urandom_range(0, 99) < p_rdy);
    step($urandom_range(0, 99) < p_rst, $urandom_range(0, 99) < p_stall,
         $urandom_range(0, 99) < p_exc, rdy);
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stg_idx",   64'(sif.stg_idx_o),   64'(e.idx));
        check("stg_en",    64'(sif.stg_en_o),    64'(1 << e.idx));
        check("stg_first", 64'(sif.stg_first_o), 64'(e.first));
        check("retire",    64'(sif.retire_o),    64'(e.retire));
        check("tmo",       64'(sif.tmo_o),       64'(e.tmo));
        check("instret",   64'(sif.instret_o),   64'(e.instret));
`ifdef STAGE_SEQ_PERF_EN
        check("cyc_cnt",   64'(cyc_cnt),         64'(e.cyc));
        check("stall_cnt", 64'(stall_cnt),       64'(e.stl));
`endif
      end
    end
  end

  initial begin
    rst_i           = 1'b1;
    sif.stall_i     = 1'b0;
    sif.exc_i       = 1'b0;
    sif.stg_ready_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;

    // Reset state, then free-running with every ready high.
    step(1, 0, 0, '0);
    repeat (8) step(0, 0, 0, '1);

    // Stall in stage 2 with ready high, then release.
    goto_stage(2);
    repeat (5) step(0, 1, 0, '1);
    repeat (2) step(0, 0, 0, '1);

    // Exception in the last stage while it is ready.
    goto_stage(3);
    step(0, 0, 1, '1);
    step(0, 0, 0, '0);
    // Exception while already in the redirect stage.
    step(0, 0, 1, '0);
    step(0, 0, 0, '0);

    // Watchdog timeout in stage 2; the flag must stay set afterwards.
    goto_stage(2);
    repeat (20) step(0, 0, 0, '0);
    repeat (12) step(0, 0, 0, '1);

    // Stall part-way to timeout must freeze the watchdog.
    goto_stage(2);
    repeat (10) step(0, 0, 0, '0);
    repeat (6) step(0, 1, 0, '0);
    repeat (8) step(0, 0, 0, '0);

    // Reset during stall plus exception.
    step(0, 1, 0, '0);
    step(1, 1, 1, '1);
    step(0, 0, 0, '0);

    // Ten cycles, three of them stalled, straight after reset.
    step(1, 0, 0, '0);
    for (int i = 0; i < 10; i++) step(0, (i == 2 || i == 5 || i == 6), 0, '1);
    step(0, 0, 0, '0);

    // Randomised traffic, alternating busy and starved phases.
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 200; i++) begin
        if (blk % 2 == 0) rand_step(1, 4, 15, 60);
        else              rand_step(1, 2, 10, 4);
      end
    end

    repeat (3) @(posedge clk_i);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
